// File: rtl/ram_arbiter_if.sv
// Request/response port of one RAM master as seen by the arbiter.
interface ram_arbiter_if;
    logic        req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter and access sequencer for a single-port word RAM.
// One latched access at a time: IDLE -> ACCESS (1+WAIT cycles) -> RESP.
module ram_arbiter #(
    parameter int WAIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave m0,
    ram_arbiter_if.slave m1,
    output logic         ram_r,
    output logic [3:0]   ram_w,
    output logic [31:0]  ram_in,
    output logic [31:0]  ram_addr,
    input  logic [31:0]  ram_out
);
    localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          last_q, last_d;
    logic          lat_id_q, lat_id_d;
    logic [3:0]    lat_we_q, lat_we_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [31:0]   rdata0_q, rdata0_d;
    logic [31:0]   rdata1_q, rdata1_d;
    logic          ram_r_q, ram_r_d;
    logic [3:0]    ram_w_q, ram_w_d;
    logic [31:0]   ram_in_q, ram_in_d;
    logic [31:0]   ram_addr_q, ram_addr_d;
    logic          win;
    logic [3:0]    sel_we;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;

    // Round-robin pick: on a tie the master not granted last time wins.
    always_comb begin
        win = 1'b0;
        if (m0.req && m1.req) begin
            win = ~last_q;
        end else if (m1.req) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
    end

    assign sel_we    = win ? m1.we    : m0.we;
    assign sel_addr  = win ? m1.addr  : m0.addr;
    assign sel_wdata = win ? m1.wdata : m0.wdata;
    assign cnt_inc   = cnt_q + {{(CW-1){1'b0}}, 1'b1};

    // Next-state and next-output logic; RAM outputs are computed for the coming cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        lat_id_d   = lat_id_q;
        lat_we_d   = lat_we_q;
        gnt_d      = 2'b00;
        rvalid_d   = 2'b00;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        ram_r_d    = 1'b0;
        ram_w_d    = 4'b0000;
        ram_in_d   = 32'h0000_0000;
        ram_addr_d = 32'h0000_0000;
        case (state_q)
            IDLE: begin
                if (m0.req || m1.req) begin
                    state_d    = ACCESS;
                    cnt_d      = {CW{1'b0}};
                    last_d     = win;
                    lat_id_d   = win;
                    lat_we_d   = sel_we;
                    ram_addr_d = sel_addr;
                    ram_in_d   = sel_wdata;
                    ram_r_d    = (sel_we == 4'b0000);
                    ram_w_d    = (CNT_LAST == {CW{1'b0}}) ? sel_we : 4'b0000;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d            = RESP;
                    gnt_d[lat_id_q]    = 1'b1;
                    rvalid_d[lat_id_q] = (lat_we_q == 4'b0000);
                    // ram_out still reflects the access address at this edge
                    if ((lat_we_q == 4'b0000) && !lat_id_q) begin
                        rdata0_d = ram_out;
                    end else begin
                        rdata0_d = rdata0_q;
                    end
                    if ((lat_we_q == 4'b0000) && lat_id_q) begin
                        rdata1_d = ram_out;
                    end else begin
                        rdata1_d = rdata1_q;
                    end
                end else begin
                    cnt_d      = cnt_inc;
                    ram_addr_d = ram_addr_q;
                    ram_in_d   = ram_in_q;
                    ram_r_d    = ram_r_q;
                    ram_w_d    = (cnt_inc == CNT_LAST) ? lat_we_q : 4'b0000;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= {CW{1'b0}};
            last_q     <= 1'b1;
            lat_id_q   <= 1'b0;
            lat_we_q   <= 4'b0000;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            rdata0_q   <= 32'h0000_0000;
            rdata1_q   <= 32'h0000_0000;
            ram_r_q    <= 1'b0;
            ram_w_q    <= 4'b0000;
            ram_in_q   <= 32'h0000_0000;
            ram_addr_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            lat_id_q   <= lat_id_d;
            lat_we_q   <= lat_we_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            ram_r_q    <= ram_r_d;
            ram_w_q    <= ram_w_d;
            ram_in_q   <= ram_in_d;
            ram_addr_q <= ram_addr_d;
        end
    end

    assign m0.gnt    = gnt_q[0];
    assign m1.gnt    = gnt_q[1];
    assign m0.rvalid = rvalid_q[0];
    assign m1.rvalid = rvalid_q[1];
    assign m0.rdata  = rdata0_q;
    assign m1.rdata  = rdata1_q;
    assign ram_r     = ram_r_q;
    // A reset cycle must never let a write strobe reach the RAM's negedge write.
    assign ram_w     = ram_w_q & {4{~rst}};
    assign ram_in    = ram_in_q;
    assign ram_addr  = ram_addr_q;
endmodule
